// File: rtl/subdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subdiv_pkg
// Description : Shared types and constants for the subdivision pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package subdiv_pkg;

    localparam int          ADDR_WIDTH = 9;
    localparam logic [31:0] Q_ONE      = 32'h0001_0000;

    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_CLEAR   = 4'd1;
    localparam state_t ST_FACE    = 4'd2;
    localparam state_t ST_FACE_RD = 4'd3;
    localparam state_t ST_PAIR    = 4'd4;
    localparam state_t ST_CNT_RD  = 4'd5;
    localparam state_t ST_SCAN    = 4'd6;
    localparam state_t ST_APPEND  = 4'd7;

    typedef logic [1:0] vsel_t;
    localparam vsel_t SEL_A = 2'd0;
    localparam vsel_t SEL_B = 2'd1;
    localparam vsel_t SEL_C = 2'd2;

    typedef struct packed {
        vsel_t src;
        vsel_t dst;
    } pair_sel_t;

    // Entry p sits at bits [4p+3:4p]: (a,b),(b,a),(b,c),(c,b),(c,a),(a,c)
    localparam logic [23:0] c_PAIR_ORDER = {
        {SEL_A, SEL_C}, {SEL_C, SEL_A}, {SEL_C, SEL_B},
        {SEL_B, SEL_C}, {SEL_B, SEL_A}, {SEL_A, SEL_B}
    };

    function automatic pair_sel_t pair_sel(input logic [2:0] p);
        logic [31:0] tbl;
        tbl = {8'h00, c_PAIR_ORDER};
        return pair_sel_t'(tbl[p*4 +: 4]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nbr_slot_scan.sv
`default_nettype none
// ============================================================================
// Module      : nbr_slot_scan
// Description : Streams the neighbour words of one slot and reports a match.
// Revision    : 1.0 - initial release
// ============================================================================
module nbr_slot_scan
    import subdiv_pkg::*;
#(
    parameter int ADDR_WIDTH = subdiv_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [31:0]           i_count,
    input  logic [31:0]           i_dst,
    input  logic [31:0]           i_rd_data,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_done,
    output logic                  o_found
);

    logic                  r_active;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [31:0]           r_cnt;
    logic [31:0]           r_dst;
    logic [31:0]           r_issued;
    logic [31:0]           r_recv;
    logic                  r_done;
    logic                  r_found;

    // r_rd_en doubles as "read data valid now" for the read issued one edge ago
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_cnt     <= '0;
            r_dst     <= '0;
            r_issued  <= '0;
            r_recv    <= '0;
            r_done    <= 1'b0;
            r_found   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_found <= 1'b0;
                r_recv  <= '0;
                r_cnt   <= i_count;
                r_dst   <= i_dst;
                if (i_count == 32'd0) begin
                    r_done   <= 1'b1;
                    r_active <= 1'b0;
                    r_rd_en  <= 1'b0;
                end else begin
                    r_active  <= 1'b1;
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= i_base + ADDR_WIDTH'(1);
                    r_issued  <= 32'd1;
                end
            end else if (r_active) begin
                if (r_rd_en && (i_rd_data == r_dst)) begin
                    r_found  <= 1'b1;
                    r_done   <= 1'b1;
                    r_active <= 1'b0;
                    r_rd_en  <= 1'b0;
                end else if (r_rd_en && (r_recv == r_cnt - 32'd1)) begin
                    r_done   <= 1'b1;
                    r_active <= 1'b0;
                    r_rd_en  <= 1'b0;
                end else begin
                    if (r_rd_en) begin
                        r_recv <= r_recv + 32'd1;
                    end
                    if (r_issued < r_cnt) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                        r_issued  <= r_issued + 32'd1;
                    end else begin
                        r_rd_en <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_rd_en   = r_rd_en;
    assign o_rd_addr = r_rd_en ? r_rd_addr : '0;
    assign o_done    = r_done;
    assign o_found   = r_found;

endmodule
`default_nettype wire

// File: rtl/neighbor_builder.sv
`default_nettype none
// ============================================================================
// Module      : neighbor_builder
// Description : Walks the face list and builds the per-vertex neighbour table.
// Revision    : 1.0 - initial release
// ============================================================================
module neighbor_builder
    import subdiv_pkg::*;
#(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH         = subdiv_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    input  logic [31:0]           RAM_OBJ_Do,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_OBJ_EN,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [3:0]            RAM_OBJ_WE,
    output logic                  RAM_NBR_EN,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [3:0]            RAM_NBR_WE,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  idx_err
);

    localparam logic [ADDR_WIDTH-1:0] c_MAX_A  = ADDR_WIDTH'(MAX_NEIGHBOR_COUNT);
    localparam logic [31:0]           c_MAX_M1 = 32'(MAX_NEIGHBOR_COUNT - 1);

    state_t                r_state;
    logic [31:0]           r_v;
    logic [31:0]           r_f;
    logic [31:0]           r_face;
    logic [31:0]           r_vidx;
    logic [31:0]           r_a;
    logic [31:0]           r_b;
    logic [31:0]           r_c;
    logic [31:0]           r_dst;
    logic [31:0]           r_count;
    logic [ADDR_WIDTH-1:0] r_fbase;
    logic [ADDR_WIDTH-1:0] r_clr_a;
    logic [ADDR_WIDTH-1:0] r_sbase;
    logic [2:0]            r_pair;
    logic [1:0]            r_phase;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overflow;
    logic                  r_idx_err;
    logic                  r_obj_en;
    logic [ADDR_WIDTH-1:0] r_obj_a;
    logic                  r_nbr_en;
    logic [ADDR_WIDTH-1:0] r_nbr_a;
    logic [3:0]            r_nbr_we;
    logic [31:0]           r_nbr_di;

    pair_sel_t             w_sel;
    logic [31:0]           w_src;
    logic [31:0]           w_dst;
    logic                  w_pair_ok;
    logic [ADDR_WIDTH-1:0] w_src_base;
    logic [ADDR_WIDTH-1:0] w_v_lo;
    logic [ADDR_WIDTH-1:0] w_fbase0;
    logic                  w_scan_start;
    logic                  w_scan_en;
    logic [ADDR_WIDTH-1:0] w_scan_a;
    logic                  w_scan_done;
    logic                  w_scan_found;

    assign w_sel = pair_sel(r_pair);
    assign w_src = (w_sel.src == SEL_A) ? r_a : (w_sel.src == SEL_B) ? r_b : r_c;
    assign w_dst = (w_sel.dst == SEL_A) ? r_a : (w_sel.dst == SEL_B) ? r_b : r_c;
    assign w_pair_ok = (w_src != 32'd0) && (w_src <= r_v) &&
                       (w_dst != 32'd0) && (w_dst <= r_v);
    assign w_src_base = (w_src[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1)) * c_MAX_A;
    assign w_v_lo     = vertex_count[ADDR_WIDTH-1:0];
    assign w_fbase0   = w_v_lo + w_v_lo + w_v_lo + ADDR_WIDTH'(1);

    // The count word is on RAM_NBR_Do in CNT_RD; only non-empty slots need a scan
    assign w_scan_start = (r_state == ST_CNT_RD) && (RAM_NBR_Do != 32'd0);

    nbr_slot_scan #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_scan_start),
        .i_base    (r_sbase),
        .i_count   (RAM_NBR_Do),
        .i_dst     (r_dst),
        .i_rd_data (RAM_NBR_Do),
        .o_rd_en   (w_scan_en),
        .o_rd_addr (w_scan_a),
        .o_done    (w_scan_done),
        .o_found   (w_scan_found)
    );

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_v        <= '0;
            r_f        <= '0;
            r_face     <= '0;
            r_vidx     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_dst      <= '0;
            r_count    <= '0;
            r_fbase    <= '0;
            r_clr_a    <= '0;
            r_sbase    <= '0;
            r_pair     <= '0;
            r_phase    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_idx_err  <= 1'b0;
            r_obj_en   <= 1'b0;
            r_obj_a    <= '0;
            r_nbr_en   <= 1'b0;
            r_nbr_a    <= '0;
            r_nbr_we   <= '0;
            r_nbr_di   <= '0;
        end else begin
            r_done   <= 1'b0;
            r_obj_en <= 1'b0;
            r_obj_a  <= '0;
            r_nbr_en <= 1'b0;
            r_nbr_a  <= '0;
            r_nbr_we <= '0;
            r_nbr_di <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_overflow <= 1'b0;
                        r_idx_err  <= 1'b0;
                        r_v        <= vertex_count;
                        r_f        <= face_count;
                        r_face     <= '0;
                        r_fbase    <= w_fbase0;
                        if (vertex_count != 32'd0) begin
                            r_nbr_en <= 1'b1;
                            r_nbr_we <= 4'hF;
                            r_clr_a  <= c_MAX_A;
                            r_vidx   <= 32'd1;
                            r_state  <= ST_CLEAR;
                        end else begin
                            r_state <= ST_FACE;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_vidx == r_v) begin
                        r_state <= ST_FACE;
                    end else begin
                        r_nbr_en <= 1'b1;
                        r_nbr_we <= 4'hF;
                        r_nbr_a  <= r_clr_a;
                        r_clr_a  <= r_clr_a + c_MAX_A;
                        r_vidx   <= r_vidx + 32'd1;
                    end
                end
                ST_FACE: begin
                    if (r_face == r_f) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_obj_en <= 1'b1;
                        r_obj_a  <= r_fbase;
                        r_phase  <= 2'd0;
                        r_state  <= ST_FACE_RD;
                    end
                end
                ST_FACE_RD: begin
                    case (r_phase)
                        2'd0: begin
                            r_a      <= RAM_OBJ_Do;
                            r_obj_en <= 1'b1;
                            r_obj_a  <= r_fbase + ADDR_WIDTH'(1);
                            r_phase  <= 2'd1;
                        end
                        2'd1: begin
                            r_b      <= RAM_OBJ_Do;
                            r_obj_en <= 1'b1;
                            r_obj_a  <= r_fbase + ADDR_WIDTH'(2);
                            r_phase  <= 2'd2;
                        end
                        default: begin
                            r_c     <= RAM_OBJ_Do;
                            r_pair  <= 3'd0;
                            r_state <= ST_PAIR;
                        end
                    endcase
                end
                ST_PAIR: begin
                    if (r_pair == 3'd6) begin
                        r_face  <= r_face + 32'd1;
                        r_fbase <= r_fbase + ADDR_WIDTH'(3);
                        r_state <= ST_FACE;
                    end else if (!w_pair_ok) begin
                        r_idx_err <= 1'b1;
                        r_pair    <= r_pair + 3'd1;
                    end else begin
                        r_dst    <= w_dst;
                        r_sbase  <= w_src_base;
                        r_nbr_en <= 1'b1;
                        r_nbr_a  <= w_src_base;
                        r_state  <= ST_CNT_RD;
                    end
                end
                ST_CNT_RD: begin
                    r_count <= RAM_NBR_Do;
                    r_phase <= 2'd0;
                    r_state <= (RAM_NBR_Do == 32'd0) ? ST_APPEND : ST_SCAN;
                end
                ST_SCAN: begin
                    if (w_scan_done) begin
                        if (w_scan_found) begin
                            r_pair  <= r_pair + 3'd1;
                            r_state <= ST_PAIR;
                        end else begin
                            r_phase <= 2'd0;
                            r_state <= ST_APPEND;
                        end
                    end
                end
                ST_APPEND: begin
                    if (r_phase == 2'd0) begin
                        if (r_count >= c_MAX_M1) begin
                            r_overflow <= 1'b1;
                            r_pair     <= r_pair + 3'd1;
                            r_state    <= ST_PAIR;
                        end else begin
                            r_nbr_en <= 1'b1;
                            r_nbr_we <= 4'hF;
                            r_nbr_a  <= r_sbase + r_count[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                            r_nbr_di <= r_dst;
                            r_phase  <= 2'd1;
                        end
                    end else begin
                        // Count is bumped only after the neighbour word has landed
                        r_nbr_en <= 1'b1;
                        r_nbr_we <= 4'hF;
                        r_nbr_a  <= r_sbase;
                        r_nbr_di <= r_count + 32'd1;
                        r_pair   <= r_pair + 3'd1;
                        r_state  <= ST_PAIR;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign RAM_OBJ_EN = r_obj_en;
    assign RAM_OBJ_A  = r_obj_a;
    assign RAM_OBJ_WE = 4'h0;
    assign RAM_NBR_EN = r_nbr_en | w_scan_en;
    assign RAM_NBR_A  = r_nbr_a | w_scan_a;
    assign RAM_NBR_WE = r_nbr_we;
    assign RAM_NBR_Di = r_nbr_di;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign idx_err    = r_idx_err;

endmodule
`default_nettype wire

// File: tb/tb_neighbor_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_neighbor_builder
// Description : Directed self-checking bench for neighbor_builder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neighbor_builder;

    logic        clk;
    logic        rst_n;
    logic        start, start4;
    logic [31:0] vertex_count, face_count, vc4, fc4;
    logic [31:0] obj_do, nbr_do, obj_do4, nbr_do4;
    logic        obj_en, nbr_en, obj_en4, nbr_en4;
    logic [8:0]  obj_a, nbr_a, obj_a4, nbr_a4;
    logic [3:0]  obj_we, nbr_we, obj_we4, nbr_we4;
    logic [31:0] nbr_di, nbr_di4;
    logic        busy, done, overflow, idx_err;
    logic        busy4, done4, overflow4, idx_err4;

    logic [31:0] obj_mem  [512];
    logic [31:0] nbr_mem  [512];
    logic [31:0] obj_mem4 [512];
    logic [31:0] nbr_mem4 [512];

    logic        fill_req;
    logic [31:0] fill_val;
    int          done_cnt, done_cnt4, nbr_wr_cnt;
    bit          obj_we_bad;
    int          checks, errors;

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(10), .ADDR_WIDTH(9)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_Do(obj_do), .RAM_NBR_Do(nbr_do),
        .RAM_OBJ_EN(obj_en), .RAM_OBJ_A(obj_a), .RAM_OBJ_WE(obj_we),
        .RAM_NBR_EN(nbr_en), .RAM_NBR_A(nbr_a), .RAM_NBR_WE(nbr_we), .RAM_NBR_Di(nbr_di),
        .busy(busy), .done(done), .overflow(overflow), .idx_err(idx_err)
    );

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(4), .ADDR_WIDTH(9)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .vertex_count(vc4), .face_count(fc4),
        .RAM_OBJ_Do(obj_do4), .RAM_NBR_Do(nbr_do4),
        .RAM_OBJ_EN(obj_en4), .RAM_OBJ_A(obj_a4), .RAM_OBJ_WE(obj_we4),
        .RAM_NBR_EN(nbr_en4), .RAM_NBR_A(nbr_a4), .RAM_NBR_WE(nbr_we4), .RAM_NBR_Di(nbr_di4),
        .busy(busy4), .done(done4), .overflow(overflow4), .idx_err(idx_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM models: address registered on the rising edge between
    // the DUT's falling-edge updates, so read data is ready one falling edge later.
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 512; i++) begin
                nbr_mem[i]  <= fill_val;
                nbr_mem4[i] <= fill_val;
            end
        end else begin
            if (nbr_en) begin
                if (nbr_we == 4'hF) begin
                    nbr_mem[nbr_a] <= nbr_di;
                end
                nbr_do <= nbr_mem[nbr_a];
            end
            if (nbr_en4) begin
                if (nbr_we4 == 4'hF) begin
                    nbr_mem4[nbr_a4] <= nbr_di4;
                end
                nbr_do4 <= nbr_mem4[nbr_a4];
            end
        end
        if (obj_en)  obj_do  <= obj_mem[obj_a];
        if (obj_en4) obj_do4 <= obj_mem4[obj_a4];
        if (done)  done_cnt  <= done_cnt + 1;
        if (done4) done_cnt4 <= done_cnt4 + 1;
        if (nbr_we != 4'h0) nbr_wr_cnt <= nbr_wr_cnt + 1;
        if (obj_we !== 4'h0 || obj_we4 !== 4'h0) obj_we_bad <= 1'b1;
    end

    task automatic fill_nbr(input logic [31:0] val);
        #1;
        fill_val = val;
        fill_req = 1'b1;
        @(posedge clk);
        #1 fill_req = 1'b0;
    endtask

    task automatic put_face(input bit sel4, input int v, input int f,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        int base;
        base = 3 * v + 1 + 3 * f;
        if (sel4) begin
            obj_mem4[base] = a; obj_mem4[base+1] = b; obj_mem4[base+2] = c;
        end else begin
            obj_mem[base] = a; obj_mem[base+1] = b; obj_mem[base+2] = c;
        end
    endtask

    task automatic run_build(input bit sel4, input logic [31:0] v, input logic [31:0] f,
                             input int poke, output bit timed_out);
        bit seen;
        seen = 1'b0;
        @(posedge clk);
        #1;
        if (sel4) begin
            vc4 = v; fc4 = f; start4 = 1'b1;
        end else begin
            vertex_count = v; face_count = f; start = 1'b1;
        end
        @(posedge clk);
        #1 start = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (i == poke) start = 1'b1;
            @(posedge clk);
            if (sel4 ? done4 : done) seen = 1'b1;
            #1 start = 1'b0;
        end
        timed_out = !seen;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, overflow, idx_err, obj_en, obj_we, nbr_en, nbr_we} !== 12'h0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0",
                     {busy, done, overflow, idx_err, obj_en, obj_we, nbr_en, nbr_we});
        end
        checks++;
        if ({obj_a, nbr_a, nbr_di} !== 50'h0) begin
            errors++;
            $display("FAIL reset_bus got %h want 0", {obj_a, nbr_a, nbr_di});
        end
        checks++;
        if ({busy4, done4, overflow4, idx_err4, nbr_en4, nbr_we4} !== 9'h0) begin
            errors++;
            $display("FAIL reset_dut4 got %b want 0", {busy4, done4, overflow4, idx_err4, nbr_en4, nbr_we4});
        end
    endtask

    task automatic test_single_triangle(input logic [31:0] preload, input int poke);
        int unsigned ea [9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
        logic [31:0] ed [9] = '{2, 2, 3, 2, 1, 3, 2, 2, 1};
        bit to;
        int d0;
        fill_nbr(preload);
        put_face(1'b0, 3, 0, 1, 2, 3);
        d0 = done_cnt;
        run_build(1'b0, 3, 1, poke, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL tri_timeout got %0b want 0", to); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL tri_done_pulses got %0d want 1", done_cnt - d0); end
        checks++;
        if ({busy, overflow, idx_err} !== 3'b000) begin
            errors++; $display("FAIL tri_flags got %b want 000", {busy, overflow, idx_err});
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (nbr_mem[ea[i]] !== ed[i]) begin
                errors++;
                $display("FAIL tri_nbr[%0d] got %0h want %0h", ea[i], nbr_mem[ea[i]], ed[i]);
            end
        end
    endtask

    task automatic check_quad(input int d0, input bit to);
        int unsigned ea [15] = '{0, 1, 2, 3, 10, 11, 12, 20, 21, 22, 23, 30, 31, 32, 40};
        logic [31:0] ed [15] = '{3, 2, 3, 4, 2, 1, 3, 3, 2, 1, 4, 2, 3, 1, 32'hA5A5_A5A5};
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL quad_timeout got %0b want 0", to); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL quad_done_pulses got %0d want 1", done_cnt - d0); end
        checks++;
        if ({busy, overflow, idx_err} !== 3'b000) begin
            errors++; $display("FAIL quad_flags got %b want 000", {busy, overflow, idx_err});
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (nbr_mem[ea[i]] !== ed[i]) begin
                errors++;
                $display("FAIL quad_nbr[%0d] got %0h want %0h", ea[i], nbr_mem[ea[i]], ed[i]);
            end
        end
    endtask

    task automatic test_quad;
        bit to;
        int d0;
        fill_nbr(32'hA5A5_A5A5);
        put_face(1'b0, 4, 0, 1, 2, 3);
        put_face(1'b0, 4, 1, 1, 3, 4);
        d0 = done_cnt;
        run_build(1'b0, 4, 2, -1, to);
        check_quad(d0, to);
    endtask

    task automatic test_overflow;
        int unsigned ea [10] = '{0, 1, 2, 3, 4, 5, 6, 20, 21, 22};
        logic [31:0] ed [10] = '{3, 2, 3, 4, 2, 1, 3, 2, 5, 1};
        bit to;
        fill_nbr(32'h7777_7777);
        put_face(1'b1, 6, 0, 1, 2, 3);
        put_face(1'b1, 6, 1, 1, 3, 4);
        put_face(1'b1, 6, 2, 1, 4, 5);
        put_face(1'b1, 6, 3, 1, 5, 6);
        run_build(1'b1, 6, 4, -1, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL ovf_timeout got %0b want 0", to); end
        checks++;
        if ({overflow4, idx_err4} !== 2'b10) begin
            errors++; $display("FAIL ovf_flags got %b want 10", {overflow4, idx_err4});
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (nbr_mem4[ea[i]] !== ed[i]) begin
                errors++;
                $display("FAIL ovf_nbr[%0d] got %0h want %0h", ea[i], nbr_mem4[ea[i]], ed[i]);
            end
        end
    endtask

    task automatic test_idx_err;
        int unsigned ea [5] = '{0, 1, 10, 11, 20};
        logic [31:0] ed [5] = '{1, 2, 1, 1, 0};
        bit to;
        fill_nbr(32'h3C3C_3C3C);
        put_face(1'b0, 3, 0, 1, 2, 9);
        run_build(1'b0, 3, 1, -1, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL idx_timeout got %0b want 0", to); end
        checks++;
        if ({overflow, idx_err} !== 2'b01) begin
            errors++; $display("FAIL idx_flags got %b want 01", {overflow, idx_err});
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (nbr_mem[ea[i]] !== ed[i]) begin
                errors++;
                $display("FAIL idx_nbr[%0d] got %0h want %0h", ea[i], nbr_mem[ea[i]], ed[i]);
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        bit hit, to;
        int w0, d0;
        hit = 1'b0;
        fill_nbr(32'hA5A5_A5A5);
        put_face(1'b0, 4, 0, 1, 2, 3);
        put_face(1'b0, 4, 1, 1, 3, 4);
        @(posedge clk);
        #1 vertex_count = 4; face_count = 2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // A read off a slot base can only be a scan read
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(posedge clk);
            if (nbr_en && nbr_we == 4'h0 && (nbr_a % 10) != 0) hit = 1'b1;
        end
        checks++;
        if (hit !== 1'b1) begin errors++; $display("FAIL rst_scan_seen got %0b want 1", hit); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, nbr_we, nbr_en} !== 6'h0) begin
            errors++; $display("FAIL rst_mid_outputs got %b want 0", {busy, nbr_we, nbr_en});
        end
        w0 = nbr_wr_cnt;
        repeat (5) @(posedge clk);
        checks++;
        if (nbr_wr_cnt !== w0) begin
            errors++; $display("FAIL rst_no_writes got %0d want %0d", nbr_wr_cnt, w0);
        end
        #1 rst_n = 1'b1;
        d0 = done_cnt;
        run_build(1'b0, 4, 2, -1, to);
        check_quad(d0, to);
    endtask

    initial begin
        checks = 0; errors = 0;
        done_cnt = 0; done_cnt4 = 0; nbr_wr_cnt = 0; obj_we_bad = 1'b0;
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0; fill_req = 1'b0; fill_val = '0;
        vertex_count = '0; face_count = '0; vc4 = '0; fc4 = '0;
        for (int i = 0; i < 512; i++) begin
            obj_mem[i] = 32'h0; obj_mem4[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_single_triangle(32'h0, -1);
        test_quad();
        test_overflow();
        test_idx_err();
        test_single_triangle(32'hDEAD_BEEF, 5);
        test_reset_mid_scan();
        checks++;
        if (obj_we_bad !== 1'b0) begin errors++; $display("FAIL obj_we_zero got %0b want 0", obj_we_bad); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neighbor_builder.md
Name: neighbor_builder

Overview:
- Upstream stage of the vertex averager.
- Walks the face list in object RAM and builds the per-vertex neighbour table in neighbour RAM, in exactly the layout the averager consumes.
- Runs once per subdivision pass, before the averager is started; shares the same single-port 32-bit RAM macros.

Parameters:
MAX_NEIGHBOR_COUNT, 10, words per vertex slot in neighbour RAM (1 count word + up to MAX_NEIGHBOR_COUNT-1 neighbours)
ADDR_WIDTH, 9, RAM word-address width

Ports:
clk  in  1  clock; all state updates on falling edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin build; sampled in IDLE only
vertex_count  in  32  number of vertices V
face_count  in  32  number of triangles F
RAM_OBJ_Do  in  32  object RAM read data
RAM_NBR_Do  in  32  neighbour RAM read data
RAM_OBJ_EN  out  1  object RAM enable
RAM_OBJ_A  out  ADDR_WIDTH  object RAM address
RAM_OBJ_WE  out  4  object RAM byte write enables, always 0
RAM_NBR_EN  out  1  neighbour RAM enable
RAM_NBR_A  out  ADDR_WIDTH  neighbour RAM address
RAM_NBR_WE  out  4  neighbour RAM byte write enables
RAM_NBR_Di  out  32  neighbour RAM write data
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the build completes
overflow  out  1  sticky: a neighbour was dropped because its slot was full
idx_err  out  1  sticky: a face index was 0 or greater than V

Behaviour:
- Reset and IDLE outputs: all EN/WE/A/Di = 0; busy, done, overflow, idx_err = 0. Reset asserted mid-build forces IDLE immediately; no further RAM writes occur.
- RAM timing: address driven at falling edge N; Do is valid at falling edge N+1. Writes use WE=4'b1111 for one cycle.
- Object RAM layout:
  - vertex i (0-based) occupies addresses 3i+1..3i+3;
  - face f (0-based) occupies 3V+1+3f..3V+3+3f as three 1-based vertex indices a,b,c.
- Neighbour RAM layout: slot base S(v) = v*MAX_NEIGHBOR_COUNT; word S(v) holds the count; words S(v)+1..S(v)+count hold 1-based neighbour indices.
- start in IDLE: clears overflow/idx_err, sets busy, latches V and F. start while busy is ignored.
- States:
  - CLEAR: write 0 to S(v) for v=0..V-1, one per cycle. Skipped if V=0.
  - FACE_RD: read a, b, c of the current face (3 reads, pipelined).
  - PAIR: select directed pair p=0..5 in order (a,b),(b,a),(b,c),(c,b),(c,a),(a,c) as (src,dst). If src or dst is 0 or >V: set idx_err, skip the pair.
  - CNT_RD: read count at S(src-1).
  - SCAN: read words S(src-1)+1..+count and compare each to dst. On a match, skip the pair (no writes). count=0 goes straight to APPEND.
  - APPEND: if count == MAX_NEIGHBOR_COUNT-1, set overflow and skip. Otherwise write dst to S(src-1)+count+1, then write count+1 to S(src-1) on the next cycle.
  - After pair 5, advance the face. After face F-1 (or immediately if F=0), pulse done, drop busy and return to IDLE.
- Address arithmetic is done in ADDR_WIDTH bits and wraps silently. The caller guarantees V*MAX_NEIGHBOR_COUNT ≤ 2^ADDR_WIDTH and 3(V+F)+1 ≤ 2^ADDR_WIDTH.
- Neighbours are stored in first-seen order. Duplicate edges from shared faces never duplicate an entry.

Decomposition:
- Shared package subdiv_pkg holds: ADDR_WIDTH, Q_ONE, the state enum, and the pair-order constant table (6 entries of src/dst selectors).
- One natural sub-module, nbr_slot_scan: given the slot base, count and dst, it sequences SCAN reads and returns found/not-found. It is reusable by later stages.

Test Plan:
- Single triangle, V=3, F=1, face (1,2,3) → NBR[0..2]=2,2,3; NBR[10..12]=2,1,3; NBR[20..22]=2,2,1. done pulses once; overflow=0, idx_err=0.
- Quad, V=4, faces (1,2,3),(1,3,4) → counts 2 and 3 become v0=3 {2,3,4}, v1=2 {1,3}, v2=3 {2,1,4}, v3=2 {3,1}. Shared edge 1-3 stored once per side.
- MAX_NEIGHBOR_COUNT=4, fan around vertex 1 with 5 distinct neighbours → NBR[0]=3, overflow=1. No write outside addresses 0..3 for v0.
- V=3, face (1,2,9) → idx_err=1, v0=[2], v1=[1], v2 count 0.
- Neighbour RAM preloaded with 0xDEADBEEF, then the single-triangle run → identical to the first scenario (CLEAR verified). A second start pulse while busy produces no restart.
- rst_n low during SCAN of the quad run → busy=0 and all WE=0 within the same cycle. A fresh start then reproduces the quad result exactly.
